// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, clock out one byte with odd parity,
// then check the device ack. Both lines are driven open-drain through pull-low enables.
`timescale 1ns / 1ps
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);
    localparam int unsigned InhW = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [InhW-1:0] InhMax = InhW'(INHIBIT_CYCLES);
    localparam logic [ToW-1:0]  ToMax  = ToW'(TIMEOUT_CYCLES);
    localparam logic [3:0]      BitMax = 4'd10;

    typedef enum logic [2:0] {
        StIdle, StInhibit, StRts, StSend, StAck, StWaitIdle
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
    logic                   clk_prev_q;
    logic [InhW-1:0]        inh_cnt_q, inh_inc;
    logic [ToW-1:0]         to_cnt_q, to_inc;
    logic [3:0]             bit_cnt_q;
    logic [7:0]             byte_q;
    logic                   parity_q, send_low_q, ack_ok_q, done_q, error_q;
    logic                   clk_s, data_s, fe, timed, to_hit, lines_idle;

    // Sync flops reset to the idle (high) line level so reset never fakes a falling edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= SYNC_STAGES'({clk_sync_q, ps2_clk_in});
            data_sync_q <= SYNC_STAGES'({data_sync_q, ps2_data_in});
            clk_prev_q  <= clk_s;
        end
    end

    assign clk_s      = clk_sync_q[SYNC_STAGES-1];
    assign data_s     = data_sync_q[SYNC_STAGES-1];
    assign fe         = clk_prev_q & ~clk_s;
    assign lines_idle = clk_s & data_s;

    always_comb begin
        inh_inc = (inh_cnt_q == InhMax) ? inh_cnt_q : inh_cnt_q + InhW'(1);
        to_inc  = (to_cnt_q == ToMax) ? to_cnt_q : to_cnt_q + ToW'(1);
        timed   = (state_q == StSend) || (state_q == StAck) || (state_q == StWaitIdle);
        to_hit  = timed && (to_inc == ToMax);
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; timeout wins over a same-cycle falling edge
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:     if (tx_valid) state_d = StInhibit;
            StInhibit:  if (inh_inc == InhMax) state_d = StRts;
            StRts:      state_d = StSend;
            StSend: begin
                if (to_hit) begin
                    state_d = StIdle;
                end else if (fe && (bit_cnt_q == 4'd9)) begin
                    state_d = StAck;
                end
            end
            StAck: begin
                if (to_hit) begin
                    state_d = StIdle;
                end else if (fe) begin
                    state_d = StWaitIdle;
                end
            end
            StWaitIdle: if (to_hit || lines_idle) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // FSM outputs; decoded from state so reset releases the lines without a clock edge
    always_comb begin
        tx_ready    = (state_q == StIdle);
        busy        = (state_q != StIdle);
        ps2_clk_oe  = (state_q == StInhibit) || (state_q == StRts);
        ps2_data_oe = (state_q == StRts) || ((state_q == StSend) && send_low_q);
        tx_done     = done_q;
        tx_error    = error_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inh_cnt_q  <= '0;
            to_cnt_q   <= '0;
            bit_cnt_q  <= '0;
            byte_q     <= '0;
            parity_q   <= 1'b0;
            send_low_q <= 1'b0;
            ack_ok_q   <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            if (timed) to_cnt_q <= to_inc;
            case (state_q)
                StIdle: begin
                    if (tx_valid) begin
                        byte_q    <= tx_data;
                        parity_q  <= ~^tx_data;
                        inh_cnt_q <= '0;
                    end
                end
                StInhibit: inh_cnt_q <= inh_inc;
                StRts: begin
                    bit_cnt_q  <= '0;
                    to_cnt_q   <= '0;
                    send_low_q <= 1'b1;
                end
                StSend: begin
                    if (to_hit) begin
                        send_low_q <= 1'b0;
                        error_q    <= 1'b1;
                    end else if (fe) begin
                        if (bit_cnt_q[3] == 1'b0) begin
                            send_low_q <= ~byte_q[bit_cnt_q[2:0]];
                        end else if (bit_cnt_q == 4'd8) begin
                            send_low_q <= ~parity_q;
                        end else begin
                            send_low_q <= 1'b0;
                        end
                        if (bit_cnt_q != BitMax) bit_cnt_q <= bit_cnt_q + 4'd1;
                    end
                end
                StAck: begin
                    if (to_hit) begin
                        error_q <= 1'b1;
                    end else if (fe) begin
                        ack_ok_q <= ~data_s;
                    end
                end
                StWaitIdle: begin
                    if (to_hit) begin
                        error_q <= 1'b1;
                    end else if (lines_idle) begin
                        done_q  <= ack_ok_q;
                        error_q <= ~ack_ok_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the DUT while a per-cycle
// monitor checks line behaviour against the framing rules.
`timescale 1ns / 1ps
module tb_ps2_host_tx;
    localparam int INH = 20;
    localparam int TO  = 5000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, tx_done, tx_error;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       clk_line, data_line;

    assign clk_line  = ~(ps2_clk_oe | dev_clk_low);
    assign data_line = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO),
        .SYNC_STAGES   (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .tx_done    (tx_done),
        .tx_error   (tx_error),
        .ps2_clk_in (clk_line),
        .ps2_data_in(data_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    int         done_cnt = 0;
    int         err_cnt = 0;
    int         since = 0;
    bit         mon_en = 1'b0;
    logic [7:0] cur_byte = 8'h00;
    int         d0, e0, n;
    bit         found;
    logic [9:0] bits;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int cycles);
        repeat (cycles) @(posedge clk);
        #2;
    endtask

    // Per-cycle monitor: a frame is 20 cycles of inhibit, one of request-to-send, then release.
    initial forever begin
        @(negedge clk);
        if (reset || !mon_en) begin
            since = 0;
        end else begin
            check("ready_vs_busy", 32'(tx_ready), 32'(!busy));
            check("done_error_excl", 32'(tx_done & tx_error), 32'd0);
            if (tx_ready) check("idle_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
            if (since >= 1 && since <= INH) begin
                check("inhibit_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'b10);
            end else if (since == INH + 1) begin
                check("rts_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'b11);
            end else if (since == INH + 2) begin
                check("release_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'b01);
            end
            if (tx_done) done_cnt++;
            if (tx_error) err_cnt++;
            if (tx_valid && tx_ready) begin
                since    = 1;
                cur_byte = tx_data;
            end else if (since != 0 && since < INH + 2) begin
                since++;
            end else begin
                since = 0;
            end
        end
    end

    task automatic send(input logic [7:0] b, input bit hold);
        tx_data  = b;
        tx_valid = 1'b1;
        check("send_ready", 32'(tx_ready), 32'd1);
        tick(1);
        if (!hold) tx_valid = 1'b0;
    endtask

    // Device: wait for request-to-send, then clock 80-cycle periods sampling data on rising edges.
    // With fewer than 11 pulses it stops 10 cycles after the last fall, leaving the clock low.
    task automatic device_frame(input int pulses, input bit do_ack, output logic [9:0] got);
        bit         seen_low = 1'b0;
        bit         go = 1'b0;
        logic [7:0] b;
        logic [9:0] exp_bits;
        got = '0;
        for (int t = 0; t < 400 && !go; t++) begin
            tick(1);
            if (!clk_line) seen_low = 1'b1;
            else if (seen_low && !data_line) go = 1'b1;
        end
        check("dev_saw_rts", 32'(go), 32'd1);
        if (!go) return;
        b        = cur_byte;
        exp_bits = {1'b1, ~^b, b};
        for (int i = 0; i < pulses; i++) begin
            if (i == 10) begin
                tick(20);
                dev_data_low = do_ack;
                tick(20);
            end else begin
                tick(40);
            end
            dev_clk_low = 1'b1;
            if (i == pulses - 1 && pulses < 11) begin
                tick(10);
                return;
            end
            tick(40);
            dev_clk_low = 1'b0;
            if (i < 10) got[i] = data_line;
            else dev_data_low = 1'b0;
        end
        check("dev_frame_bits", 32'(got), 32'(exp_bits));
    endtask

    task automatic wait_result(input string name, input int dref, input int eref,
                               input bit exp_done, input bit chk_ready);
        int t = 0;
        while (done_cnt == dref && err_cnt == eref && t < 300) begin
            tick(1);
            t++;
        end
        check({name, "_in_time"}, 32'(t < 300), 32'd1);
        tick(5);
        check({name, "_done_count"}, 32'(done_cnt - dref), 32'(exp_done));
        check({name, "_error_count"}, 32'(err_cnt - eref), 32'(!exp_done));
        if (chk_ready) check({name, "_ready_after"}, 32'(tx_ready), 32'd1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: bench did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        tick(3);
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pulses", 32'({tx_done, tx_error}), 32'd0);
        check("rst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;
        tick(5);

        // 0xED, acked
        d0 = done_cnt; e0 = err_cnt;
        send(8'hED, 1'b0);
        device_frame(11, 1'b1, bits);
        check("ed_bits_literal", 32'(bits), 32'h3ED);
        wait_result("ed", d0, e0, 1'b1, 1'b1);

        // 0x07 then 0x00: parity 0 then 1
        d0 = done_cnt; e0 = err_cnt;
        send(8'h07, 1'b0);
        device_frame(11, 1'b1, bits);
        check("p07_parity_literal", 32'(bits[8]), 32'd0);
        wait_result("b07", d0, e0, 1'b1, 1'b1);
        d0 = done_cnt; e0 = err_cnt;
        send(8'h00, 1'b0);
        device_frame(11, 1'b1, bits);
        check("p00_parity_literal", 32'(bits[8]), 32'd1);
        wait_result("b00", d0, e0, 1'b1, 1'b1);

        // Missing ack
        d0 = done_cnt; e0 = err_cnt;
        send(8'h5A, 1'b0);
        device_frame(11, 1'b0, bits);
        wait_result("noack", d0, e0, 1'b0, 1'b1);

        // Device never clocks: error exactly 5000 cycles after clock release
        d0 = done_cnt; e0 = err_cnt;
        send(8'h12, 1'b0);
        found = 1'b0;
        for (int t = 0; t < 100 && !found; t++) begin
            tick(1);
            if (busy && !ps2_clk_oe && ps2_data_oe) found = 1'b1;
        end
        check("to_release_seen", 32'(found), 32'd1);
        n = 0;
        while (!tx_error && n < TO + 100) begin
            tick(1);
            n++;
            if (n == TO - 1) check("to_still_driving", 32'(ps2_data_oe), 32'd1);
        end
        check("to_cycle", 32'(n), 32'(TO));
        check("to_oe_released", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        check("to_idle", 32'(tx_ready), 32'd1);
        wait_result("timeout", d0, e0, 1'b0, 1'b1);

        // Reset after the 4th falling edge releases both lines at once
        d0 = done_cnt; e0 = err_cnt;
        send(8'h00, 1'b0);
        device_frame(4, 1'b1, bits);
        check("pre_reset_data_oe", 32'(ps2_data_oe), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("midrst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        check("midrst_ready_busy", 32'({tx_ready, busy}), 32'b10);
        check("midrst_pulses", 32'({tx_done, tx_error}), 32'd0);
        dev_clk_low = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(5);
        check("rst_abort_no_pulse", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
        d0 = done_cnt; e0 = err_cnt;
        send(8'hFF, 1'b0);
        device_frame(11, 1'b1, bits);
        check("ff_bits_literal", 32'(bits), 32'h3FF);
        wait_result("ff", d0, e0, 1'b1, 1'b1);

        // tx_valid held with new data while busy: original byte goes out, 0xAA follows
        d0 = done_cnt; e0 = err_cnt;
        send(8'h3C, 1'b1);
        tx_data = 8'hAA;
        device_frame(11, 1'b1, bits);
        check("hold_first_byte_literal", 32'(bits[7:0]), 32'h3C);
        wait_result("hold1", d0, e0, 1'b1, 1'b0);
        tx_valid = 1'b0;
        d0 = done_cnt; e0 = err_cnt;
        device_frame(11, 1'b1, bits);
        check("hold_second_byte_literal", 32'(bits), 32'h3AA);
        wait_result("hold2", d0, e0, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
